// File: rtl/serial_sub_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_sub_pkg
//  Purpose  : Shared definitions for the bit-serial subtractor. This package
//             holds the FSM state encoding and the default operand width.
//  Revision : 1.0 - initial release
// ============================================================================
package serial_sub_pkg;

  localparam int unsigned C_DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fs_cell.sv
`default_nettype none
// ============================================================================
//  Module   : fs_cell
//  Purpose  : Combinational one-bit full subtractor. It handles one bit
//             position of the serial subtraction.
//  Ports    : a    - minuend bit
//             b    - subtrahend bit
//             bin  - borrow in
//             diff - difference bit (a ^ b ^ bin)
//             bout - borrow out
//  Revision : 1.0 - initial release
// ============================================================================
module fs_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when a=0,b=1, or when the bits are equal and a borrow propagates.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module   : serial_subtractor
//  Purpose  : LSB-first bit-serial subtractor. It computes
//             d = a - b - bi (mod 2^WIDTH) in WIDTH SHIFT cycles and reports
//             the final borrow.
//  Ports    : clk   - rising-edge clock
//             rst   - synchronous active-high reset
//             start - request, accepted only in IDLE or DONE
//             a, b  - minuend / subtrahend, latched with an accepted start
//             bi    - borrow in, latched with an accepted start
//             busy  - high during SHIFT
//             done  - one-cycle pulse (DONE state); d/bo/ovf valid
//             d     - difference, held until the next DONE or reset
//             bo    - final borrow out
//             ovf   - signed overflow (only with SERIAL_SUB_OVF_EN)
//  Config   : `define SERIAL_SUB_OVF_EN to add the ovf output and its logic.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = C_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t             r_state;
  state_t             w_next;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  // Only WIDTH-1 partial bits are kept. The last difference bit goes straight
  // into d, which leaves d untouched while the operation is still running.
  logic [WIDTH-2:0]   r_res;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_d;
  logic               r_bo;

  logic               w_diff;
  logic               w_bout;
  logic [WIDTH-1:0]   w_cat;

  fs_cell u_fs_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .diff (w_diff),
    .bout (w_bout)
  );

  // The new difference bit goes in at the MSB, and earlier bits move toward the LSB.
  assign w_cat  = {w_diff, r_res};
  assign w_last = (r_cnt == C_LAST);

  // Next-state logic
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next   = SHIFT;
          w_accept = 1'b1;
        end
      end
      SHIFT: begin
        if (w_last) begin
          w_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          w_next   = SHIFT;
          w_accept = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_br  <= 1'b0;
      r_res <= '0;
      r_cnt <= '0;
      r_d   <= '0;
      r_bo  <= 1'b0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bi;
      r_res <= '0;
      r_cnt <= '0;
    end else if (r_state == SHIFT) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_bout;
      r_res <= w_cat[WIDTH-1:1];
      if (w_last) begin
        r_cnt <= '0;
        r_d   <= w_cat;
        r_bo  <= w_bout;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // On the last SHIFT cycle the operand LSBs are the original MSBs. w_diff
  // is the MSB of the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (!w_accept && (r_state == SHIFT) && w_last) begin
      r_ovf <= (r_a[0] != r_b[0]) && (w_diff != r_a[0]);
    end
  end

  assign ovf = r_ovf;
`endif

  assign busy = (r_state == SHIFT);
  assign done = (r_state == DONE);
  assign d    = r_d;
  assign bo   = r_bo;

endmodule
`default_nettype wire
